// File: rtl/tlk2711_link_ctrl.sv
// TLK2711 link sequencer: power-up, comma training, loss-of-sync retrain and orderly shutdown.
// Define TLK2711_PRBS_CHECK_EN to build the PRBS self-test state and its error counter.
//
// state | meaning
// OFF   | device disabled, waiting for start
// PWRUP | device enabled, waiting for the receiver to settle
// TRAIN | transmitting idles, counting consecutive received commas
// UP    | link trained, watching for receive error bursts
// STOP  | draining idles before power-down
// PRBS  | PRBS self-test, counting receive errors
module tlk2711_link_ctrl #(
    parameter int unsigned PWRUP_CYCLES = 8000,
    parameter int unsigned LOCK_COMMAS  = 16,
    parameter int unsigned SYNC_TIMEOUT = 65535,
    parameter int unsigned ERR_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [1:0]  i_mode,
    input  logic        i_rx_comma,
    input  logic        i_rx_err,
    output logic        o_enable,
    output logic        o_lckrefn,
    output logic        o_loopen,
    output logic        o_prbsen,
    output logic        o_testen,
    output logic        o_tx_idle,
    output logic        o_link_up,
    output logic        o_stop_ack,
    output logic        o_sync_timeout,
    output logic [2:0]  o_state,
    output logic [15:0] o_prbs_err_cnt
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PWRUP = 3'd1,
        ST_TRAIN = 3'd2,
        ST_UP    = 3'd3,
        ST_STOP  = 3'd4,
        ST_PRBS  = 3'd5
    } state_t;

    localparam logic [15:0] PWRUP_LOAD = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] TMO_LOAD   = 16'(SYNC_TIMEOUT - 1);
    // STOP entry cycle plus 16 drain cycles before the power-down/ack cycle
    localparam logic [15:0] STOP_LOAD  = 16'd16;
    localparam logic [7:0]  LOCK_VAL   = 8'(LOCK_COMMAS);
    localparam logic [3:0]  ERR_VAL    = 4'(ERR_LIMIT);

    state_t      state, state_nxt;
    logic [1:0]  mode, mode_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic [7:0]  comma_cnt, comma_nxt;
    logic [3:0]  err_cnt, err_nxt;
    logic        stop_q;
    logic        ack_nxt, tmo_nxt;
    logic        enable_nxt, loopen_nxt, prbsen_nxt, tx_idle_nxt, link_up_nxt;

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        tmr_nxt   = tmr;
        comma_nxt = comma_cnt;
        err_nxt   = err_cnt;
        ack_nxt   = 1'b0;
        tmo_nxt   = 1'b0;

        if (i_stop && state != ST_OFF && state != ST_STOP) begin
            state_nxt = ST_STOP;
            tmr_nxt   = STOP_LOAD;
        end else begin
            case (state)
                ST_OFF: begin
                    // a held i_stop acknowledges only once
                    if (i_stop) begin
                        ack_nxt = !stop_q;
                    end else if (i_start) begin
                        state_nxt = ST_PWRUP;
                        mode_nxt  = i_mode;
                        tmr_nxt   = PWRUP_LOAD;
                    end
                end
                ST_PWRUP: begin
                    if (tmr == 16'd0) begin
`ifdef TLK2711_PRBS_CHECK_EN
                        if (mode == 2'b10) begin
                            state_nxt = ST_PRBS;
                        end else begin
                            state_nxt = ST_TRAIN;
                            tmr_nxt   = TMO_LOAD;
                            comma_nxt = 8'd0;
                        end
`else
                        state_nxt = ST_TRAIN;
                        tmr_nxt   = TMO_LOAD;
                        comma_nxt = 8'd0;
`endif
                    end else begin
                        tmr_nxt = tmr - 16'd1;
                    end
                end
                ST_TRAIN: begin
                    if (comma_cnt == LOCK_VAL) begin
                        state_nxt = ST_UP;
                        err_nxt   = 4'd0;
                    end else if (tmr == 16'd0) begin
                        tmo_nxt   = 1'b1;
                        tmr_nxt   = TMO_LOAD;
                        comma_nxt = 8'd0;
                    end else begin
                        tmr_nxt   = tmr - 16'd1;
                        comma_nxt = (i_rx_comma && !i_rx_err) ? comma_cnt + 8'd1 : 8'd0;
                    end
                end
                ST_UP: begin
                    if (err_cnt == ERR_VAL) begin
                        state_nxt = ST_TRAIN;
                        tmr_nxt   = TMO_LOAD;
                        comma_nxt = 8'd0;
                    end else begin
                        err_nxt = i_rx_err ? err_cnt + 4'd1 : 4'd0;
                    end
                end
                ST_STOP: begin
                    if (tmr == 16'd0) begin
                        state_nxt = ST_OFF;
                        ack_nxt   = 1'b1;
                    end else begin
                        tmr_nxt = tmr - 16'd1;
                    end
                end
                ST_PRBS: begin
                end
                default: state_nxt = ST_OFF;
            endcase
        end

        // outputs are decoded from the next state so they register together with it
        enable_nxt  = (state_nxt != ST_OFF);
        loopen_nxt  = (state_nxt != ST_OFF) && (mode_nxt == 2'b01);
        tx_idle_nxt = (state_nxt == ST_PWRUP) || (state_nxt == ST_TRAIN) || (state_nxt == ST_STOP);
        link_up_nxt = (state_nxt == ST_UP);
`ifdef TLK2711_PRBS_CHECK_EN
        prbsen_nxt  = (state_nxt == ST_PRBS);
`else
        prbsen_nxt  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_OFF;
            mode           <= 2'b00;
            tmr            <= 16'd0;
            comma_cnt      <= 8'd0;
            err_cnt        <= 4'd0;
            stop_q         <= 1'b0;
            o_enable       <= 1'b0;
            o_lckrefn      <= 1'b0;
            o_loopen       <= 1'b0;
            o_prbsen       <= 1'b0;
            o_tx_idle      <= 1'b0;
            o_link_up      <= 1'b0;
            o_stop_ack     <= 1'b0;
            o_sync_timeout <= 1'b0;
        end else begin
            state          <= state_nxt;
            mode           <= mode_nxt;
            tmr            <= tmr_nxt;
            comma_cnt      <= comma_nxt;
            err_cnt        <= err_nxt;
            stop_q         <= i_stop;
            o_enable       <= enable_nxt;
            o_lckrefn      <= enable_nxt;
            o_loopen       <= loopen_nxt;
            o_prbsen       <= prbsen_nxt;
            o_tx_idle      <= tx_idle_nxt;
            o_link_up      <= link_up_nxt;
            o_stop_ack     <= ack_nxt;
            o_sync_timeout <= tmo_nxt;
        end
    end

`ifdef TLK2711_PRBS_CHECK_EN
    logic [15:0] prbs_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            prbs_cnt <= 16'd0;
        end else if (state == ST_OFF && state_nxt == ST_PWRUP) begin
            prbs_cnt <= 16'd0;
        end else if (state == ST_PRBS && i_rx_err && prbs_cnt != 16'hFFFF) begin
            prbs_cnt <= prbs_cnt + 16'd1;
        end
    end

    assign o_prbs_err_cnt = prbs_cnt;
`else
    assign o_prbs_err_cnt = 16'd0;
`endif

    assign o_testen = 1'b0;
    assign o_state  = state;

endmodule

// File: doc/tlk2711_link_ctrl.md
# tlk2711_link_ctrl

Link controller for the TLK2711 SerDes channel, in the clk_80 domain between the VIO/PS control inputs and the TLK2711 transmit/receive datapath. It sequences power-up, link training with K28.5 idle words, loss-of-sync recovery, optional PRBS self-test and orderly shutdown. It owns every TLK2711 static control pin. Receive status arrives already synchronised to clk.

## Interface
- PWRUP_CYCLES, 8000, cycles held in PWRUP after enabling the device (100 µs at 80 MHz); must be ≥ 1
- LOCK_COMMAS, 16, consecutive received commas required to declare link up; range 1–255
- SYNC_TIMEOUT, 65535, cycles allowed in TRAIN before a retrain; 16-bit counter
- ERR_LIMIT, 4, consecutive receive errors in UP that cause loss of sync; range 1–15

Ports:
- clk  in  1  system clock (clk_80)
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  level; bring the link up while in OFF
- i_stop  in  1  level; shut the link down; has priority over i_start
- i_mode  in  2  00 normal, 01 internal loopback, 10 PRBS test, 11 treated as 00
- i_rx_comma  in  1  received word this cycle is a K28.5 idle
- i_rx_err  in  1  received word this cycle is a code/disparity error
- o_enable  out  1  TLK2711 ENABLE
- o_lckrefn  out  1  TLK2711 LCKREFN
- o_loopen  out  1  TLK2711 LOOPEN
- o_prbsen  out  1  TLK2711 PRBSEN
- o_testen  out  1  TLK2711 TESTEN; constant 0
- o_tx_idle  out  1  datapath must transmit idle (K28.5) words
- o_link_up  out  1  link trained; datapath may send payload
- o_stop_ack  out  1  one-cycle pulse when shutdown is complete
- o_sync_timeout  out  1  one-cycle pulse on each TRAIN timeout
- o_state  out  3  OFF=0, PWRUP=1, TRAIN=2, UP=3, STOP=4, PRBS=5
- o_prbs_err_cnt  out  16  saturating PRBS error count

## Operation
- All outputs are registered.
- Reset values: every output is 0, and o_state is OFF.
- **OFF**
  - o_enable=0, o_lckrefn=0, o_tx_idle=0.
  - i_stop=1 → o_stop_ack pulses the next cycle; state stays OFF.
  - Otherwise i_start=1 → PWRUP. i_mode is latched into the mode register and the cycle counter is loaded.
- **PWRUP**
  - o_enable=1, o_lckrefn=1, o_loopen=(latched mode==01), o_tx_idle=1.
  - After PWRUP_CYCLES cycles → PRBS if latched mode==10 and PRBS is compiled in; otherwise → TRAIN.
- **TRAIN**
  - o_tx_idle=1.
  - The comma counter increments on i_rx_comma=1 and clears on i_rx_comma=0 or i_rx_err=1.
  - Counter reaches LOCK_COMMAS → UP.
  - The timeout counter reaches SYNC_TIMEOUT → o_sync_timeout pulses, both counters clear, state stays TRAIN.
- **UP**
  - o_link_up=1, o_tx_idle=0.
  - The error counter counts consecutive i_rx_err=1 and clears on any error-free cycle.
  - Counter reaches ERR_LIMIT → TRAIN; o_link_up drops in the same cycle the state changes.
- **PRBS**
  - o_prbsen=1, o_link_up=0.
  - Each i_rx_err=1 increments o_prbs_err_cnt, saturating at 0xFFFF.
  - The count clears on entry to PWRUP.
- **STOP**
  - i_stop=1 in any state other than OFF → STOP, taking priority over every other transition that cycle.
  - o_link_up=0, o_prbsen=0, o_tx_idle=1 for 16 drain cycles.
  - Then o_enable=0, o_lckrefn=0, o_stop_ack pulses for one cycle, → OFF.
  - i_stop deasserting during STOP does not abort the sequence.
- i_mode changes outside OFF are ignored until the next start.
- After STOP→OFF, a held i_start restarts the link only after i_stop=0.

## Timing
- Each state transition registers one cycle after its condition is sampled. Outputs follow in that same cycle.
- Start to o_enable=1 takes 1 cycle.
- Start to TRAIN takes 1+PWRUP_CYCLES cycles.
- TRAIN to UP takes LOCK_COMMAS cycles of clean commas, plus 1.
- i_stop to o_stop_ack takes 1+16+1 cycles: STOP entry, drain, then the power-down cycle with the ack.
- o_stop_ack and o_sync_timeout are exactly one cycle wide.
- rst=1 in any state returns the block to OFF on the next edge and aborts any sequence in progress. No o_stop_ack is issued.

## Configuration
- TLK2711_PRBS_CHECK_EN defined: the PRBS state and the o_prbs_err_cnt counter are built.
- Undefined:
  - latched mode 10 is treated as normal (PWRUP→TRAIN);
  - o_prbsen is constant 0;
  - o_prbs_err_cnt is constant 0;
  - o_state never reads 5.

## Test plan
- Normal bring-up:
  - Stimulus: PWRUP_CYCLES=8, i_mode=00, i_start=1, i_rx_comma=1 continuously.
  - Response: o_enable=1 at cycle 1, TRAIN at cycle 9, o_link_up=1 at cycle 9+16+1.
- Training timeout:
  - Stimulus: SYNC_TIMEOUT=100, i_rx_comma toggling every 4 cycles.
  - Response: o_sync_timeout pulses every 100 cycles; o_link_up stays 0.
- Loss of sync:
  - Stimulus: in UP, 3 cycles of i_rx_err, 1 clean cycle, then 4 cycles of i_rx_err.
  - Response: the link stays UP after the first burst; TRAIN follows the 4th error of the second burst.
- Stop during TRAIN:
  - Stimulus: i_stop=1 for 1 cycle.
  - Response: STOP, 16 cycles with o_tx_idle=1, then o_enable=0 with a single-cycle o_stop_ack, then OFF.
  - Same stimulus in OFF: o_stop_ack on the next cycle.
- PRBS with macro defined:
  - Stimulus: i_mode=10, 5 i_rx_err pulses.
  - Response: o_prbsen=1, o_prbs_err_cnt=5.
  - Without the macro: state reaches TRAIN and o_prbsen=0.
- Reset mid-operation:
  - Stimulus: rst=1 while UP.
  - Response: all outputs 0 and o_state=0 next cycle; no o_stop_ack.
